// File: rtl/rx_bit_timer.sv
// Bit-timing stage for the serial receiver: half-bit alignment after start, then one
// shift_strobe per bit centre and a packet_done pulse once the latched bit count is reached.
module rx_bit_timer #(
   parameter int CLK_DIV_BITS = 4,
   parameter int BIT_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic [CLK_DIV_BITS-1:0] clks_per_bit,
   input  logic [BIT_CNT_BITS-1:0] num_bits,
   output logic                    shift_strobe,
   output logic                    packet_done,
   output logic                    busy,
   output logic [BIT_CNT_BITS-1:0] bit_index
);

   typedef enum logic [1:0] {IDLE, ALIGN, RUN, DONE} state_t;

   state_t                  state_reg, state_next;
   logic [CLK_DIV_BITS-1:0] div_reg, div_next;
   logic [CLK_DIV_BITS-1:0] period_reg, period_next;
   logic [BIT_CNT_BITS-1:0] nbits_reg, nbits_next;
   logic [BIT_CNT_BITS-1:0] bit_reg, bit_next;
   logic                    strobe_reg, strobe_next;
   logic                    done_reg, done_next;
   logic                    busy_reg, busy_next;

   logic [CLK_DIV_BITS-1:0] half_period;
   logic [CLK_DIV_BITS-1:0] div_inc;
   logic [CLK_DIV_BITS-1:0] period_clamped;
   logic [BIT_CNT_BITS-1:0] nbits_clamped;
   logic [BIT_CNT_BITS-1:0] bit_inc;

   assign half_period    = period_reg >> 1;
   assign div_inc        = div_reg + CLK_DIV_BITS'(1);
   assign bit_inc        = bit_reg + BIT_CNT_BITS'(1);
   assign period_clamped = (clks_per_bit < CLK_DIV_BITS'(2)) ? CLK_DIV_BITS'(2) : clks_per_bit;
   assign nbits_clamped  = (num_bits == '0) ? BIT_CNT_BITS'(1) : num_bits;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg  <= IDLE;
         div_reg    <= '0;
         period_reg <= '0;
         nbits_reg  <= '0;
         bit_reg    <= '0;
         strobe_reg <= 1'b0;
         done_reg   <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         div_reg    <= div_next;
         period_reg <= period_next;
         nbits_reg  <= nbits_next;
         bit_reg    <= bit_next;
         strobe_reg <= strobe_next;
         done_reg   <= done_next;
         busy_reg   <= busy_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      div_next    = div_reg;
      period_next = period_reg;
      nbits_next  = nbits_reg;
      bit_next    = bit_reg;
      strobe_next = 1'b0;
      done_next   = 1'b0;
      busy_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next  = ALIGN;
               div_next    = '0;
               bit_next    = '0;
               period_next = period_clamped;
               nbits_next  = nbits_clamped;
               busy_next   = 1'b1;
            end
         end
         ALIGN: begin
            busy_next = 1'b1;
            if (div_inc == half_period) begin
               state_next = RUN;
               div_next   = '0;
            end else begin
               div_next = div_inc;
            end
         end
         RUN: begin
            busy_next = 1'b1;
            // Divider runs 1..P' so the strobe lands every P' cycles after alignment
            div_next  = (div_reg == period_reg) ? CLK_DIV_BITS'(1) : div_inc;
            if (div_next == period_reg) begin
               strobe_next = 1'b1;
               bit_next    = bit_inc;
               if (bit_inc == nbits_reg) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            done_next = 1'b1;
            busy_next = 1'b1;
            if (start) begin
               state_next  = ALIGN;
               div_next    = '0;
               bit_next    = '0;
               period_next = period_clamped;
               nbits_next  = nbits_clamped;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      // Abort overrides everything decided above, including a due strobe or a restart
      if (abort) begin
         state_next  = IDLE;
         div_next    = '0;
         bit_next    = '0;
         strobe_next = 1'b0;
         done_next   = 1'b0;
         busy_next   = 1'b0;
      end
   end

   assign shift_strobe = strobe_reg;
   assign packet_done  = done_reg;
   assign busy         = busy_reg;
   assign bit_index    = bit_reg;

endmodule
